// File: rtl/ascii_int_pkg.sv
// Shared constants and state encoding for the ASCII <-> integer byte path.
// The digit constants are also used by the ascii_4_ints digit generator.
package ascii_int_pkg;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } parse_state_t;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational classifier: flags decimal digit bytes and extracts their value.
module ascii_digit_decode
    import ascii_int_pkg::*;
(
    input  logic [7:0] in_char,
    output logic       is_digit,
    output logic [3:0] digit
);

    assign is_digit = (in_char >= ASCII_0) && (in_char <= ASCII_9);

    // '0'..'9' are 8'h30..8'h39, so the low nibble already equals the value.
    assign digit = in_char[3:0];

endmodule

// File: rtl/ascii_to_int.sv
// Streaming decimal ASCII parser: accumulates digit bytes into an unsigned
// WIDTH-bit integer (saturating) and emits it when a delimiter byte arrives.
module ascii_to_int
    import ascii_int_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_overflow
);

    parse_state_t     state;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic             is_digit;
    logic [3:0]       digit;
    logic [WIDTH:0]   acc_next;

    // acc*10 + d with saturation; returns {overflow, value}. The sum is formed
    // at WIDTH+4 bits, enough for 10*(2^WIDTH-1)+9, so the compare is exact.
    function automatic logic [WIDTH:0] mul10_add_sat(
        input logic [WIDTH-1:0] acc_in,
        input logic [3:0]       d,
        input logic             ovf_in
    );
        logic [WIDTH+3:0] wide;
        wide = ({4'd0, acc_in} << 3) + ({4'd0, acc_in} << 1) + {{WIDTH{1'b0}}, d};
        if (ovf_in || (wide > {4'd0, {WIDTH{1'b1}}})) begin
            return {1'b1, {WIDTH{1'b1}}};
        end
        return {1'b0, wide[WIDTH-1:0]};
    endfunction

    ascii_digit_decode u_decode (
        .in_char  (in_char),
        .is_digit (is_digit),
        .digit    (digit)
    );

    assign acc_next  = mul10_add_sat(acc, digit, ovf);
    assign in_ready  = (state != EMIT);
    assign out_valid = (state == EMIT);

    // Parser FSM: accumulate digits, latch result on delimiter, hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            ovf          <= 1'b0;
            out_value    <= '0;
            out_overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Delimiters here are dropped, so leading/repeated ones yield nothing.
                    if (in_valid && is_digit) begin
                        acc   <= WIDTH'(digit);
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (is_digit) begin
                            acc <= acc_next[WIDTH-1:0];
                            ovf <= acc_next[WIDTH];
                        end else begin
                            out_value    <= acc;
                            out_overflow <= ovf;
                            state        <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    // Result registers stay untouched here, so they are stable while offered.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_to_int.sv
// Self-checking bench for ascii_to_int: table of text vectors with expected
// results pushed to a scoreboard, plus hand-written multi-cycle sequences.
module tb_ascii_to_int;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] v;
        logic        o;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string       txt;
        int          nres;
        logic [15:0] v0;
        logic        o0;
        logic [15:0] v1;
        logic        o1;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];

    ascii_to_int #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_char      (in_char),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input logic [15:0] v, input logic o);
        exp_t e;
        e.v = v;
        e.o = o;
        sb.push_back(e);
    endtask

    // Present one byte and hold it until the DUT accepts it at a clock edge.
    task automatic send_byte(input logic [7:0] c);
        int n;
        in_valid = 1'b1;
        in_char  = c;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_stall: in_ready stuck low for char %0d, required 1", c);
        end
        tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, sb.size(), 0);
        repeat (3) tick();
    endtask

    task automatic set_vec(input int idx, input string txt, input int nres,
                           input logic [15:0] v0, input logic o0,
                           input logic [15:0] v1, input logic o1);
        vecs[idx].txt  = txt;
        vecs[idx].nres = nres;
        vecs[idx].v0   = v0;
        vecs[idx].o0   = o0;
        vecs[idx].v1   = v1;
        vecs[idx].o1   = o1;
    endtask

    // Scoreboard: compare each result at the cycle its handshake completes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got value %0d ovf %0d, required no output", out_value, out_overflow);
            end else begin
                e = sb.pop_front();
                check("result_value", out_value, e.v);
                check("result_ovf", out_overflow, e.o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        set_vec(0, "65535\n",      1, 16'd65535, 1'b0, 16'd0,  1'b0);
        set_vec(1, "65536\n",      1, 16'hFFFF,  1'b1, 16'd0,  1'b0);
        set_vec(2, "9999999,",     1, 16'hFFFF,  1'b1, 16'd0,  1'b0);
        set_vec(3, "ab  7,,42;",   2, 16'd7,     1'b0, 16'd42, 1'b0);
        set_vec(4, "007,",         1, 16'd7,     1'b0, 16'd0,  1'b0);
        set_vec(5, "-5 ",          1, 16'd5,     1'b0, 16'd0,  1'b0);
        set_vec(6, "0,",           1, 16'd0,     1'b0, 16'd0,  1'b0);
        set_vec(7, "6553 6:",      2, 16'd6553,  1'b0, 16'd6,  1'b0);
        set_vec(8, "65540000,1;",  2, 16'hFFFF,  1'b1, 16'd1,  1'b0);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b1;
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_value", out_value, 0);
        check("reset_out_ovf", out_overflow, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Basic number, latency and single-cycle pulse
        expect_res(16'd1234, 1'b0);
        send_str("1234 ");
        check("latency_out_valid", out_valid, 1);
        check("latency_out_value", out_value, 1234);
        tick();
        check("pulse_out_valid_low", out_valid, 0);
        check("pulse_in_ready_back", in_ready, 1);
        drain("drain_basic");

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            expect_res(vecs[i].v0, vecs[i].o0);
            if (vecs[i].nres > 1) expect_res(vecs[i].v1, vecs[i].o1);
            send_str(vecs[i].txt);
            drain($sformatf("drain_vec%0d", i));
        end

        // Backpressure: result held, next byte waits and is not lost
        out_ready = 1'b0;
        expect_res(16'd12, 1'b0);
        expect_res(16'd3, 1'b0);
        send_str("12,");
        check("bp_out_valid", out_valid, 1);
        in_valid = 1'b1;
        in_char  = 8'h33;
        repeat (4) begin
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid_held", out_valid, 1);
            check("bp_out_value_stable", out_value, 12);
            tick();
        end
        out_ready = 1'b1;
        send_str("3,");
        drain("drain_backpressure");

        // Gaps inside a number
        expect_res(16'd56, 1'b0);
        send_byte(8'h35);
        in_valid = 1'b0;
        in_char  = 8'h39;
        repeat (3) tick();
        send_str("6.");
        drain("drain_gap");

        // No delimiter: nothing emitted until one arrives
        send_str("77");
        repeat (5) begin
            tick();
            check("no_delim_quiet", out_valid, 0);
        end
        expect_res(16'd77, 1'b0);
        send_str(",");
        drain("drain_late_delim");

        // Reset mid-number discards the partial value
        send_str("98");
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_value", out_value, 0);
        check("midrst_out_ovf", out_overflow, 0);
        tick();
        rst = 1'b0;
        tick();
        expect_res(16'd1, 1'b0);
        send_str("1,");
        drain("drain_after_reset");

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
